store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
- Posted-store FIFO between the pipelined core's memory stage (memwrM / addr / write_dataM) and data_ram.
- Accepts stores in one cycle and drains them to data_ram whenever the memory port is granted.
- Forwards buffered store data to same-address loads so the core never reads stale RAM.
- Exposes full/empty/count so the hazard unit can stall the core on back-pressure.

Parameters:
- N, 10, address width in bits; matches data_ram addr.
- M, 32, data width in bits.
- DEPTH, 4, number of buffer entries; power of two, 2..16.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- st_valid  input  1  store request from core (memwrM).
- st_addr  input  N  store address.
- st_data  input  M  store data (write_dataM).
- st_ready  output  1  buffer can accept a store this cycle.
- ld_addr  input  N  address of the load currently in the memory stage.
- ld_hit  output  1  a buffered entry matches ld_addr.
- ld_data  output  M  data of the youngest matching entry; 0 when no hit.
- mem_grant  input  1  data_ram write port is free this cycle.
- mem_we  output  1  write enable to data_ram.
- mem_addr  output  N  head-entry address to data_ram.
- mem_wdata  output  M  head-entry data to data_ram.
- count  output  clog2(DEPTH)+1  number of valid entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky flag: a store was presented while full.

Behaviour:
- Storage:
  - Circular array of DEPTH entries {addr, data}.
  - wr_ptr and rd_ptr are each clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is a separate register.
- Reset (synchronous, rst=1 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Outputs follow: empty=1, full=0, st_ready=1, mem_we=0, ld_hit=0, ld_data=0.
  - Entry contents are don't-care.
  - Reset mid-operation discards all pending stores with no write to RAM, and takes priority over push/pop in that cycle.
- Push:
  - Occurs when st_valid & st_ready at posedge: entry[wr_ptr] <= {st_addr, st_data}, wr_ptr++.
  - st_ready = !full. There is no same-cycle bypass while full, even if a pop happens that cycle.
- Pop/drain:
  - mem_we = !empty & mem_grant, combinational.
  - mem_addr/mem_wdata = entry[rd_ptr], combinational; zero when empty.
  - When mem_we=1: rd_ptr++ at posedge. data_ram captures the write at the same edge.
- Latency:
  - A store pushed at edge k is eligible to drain in cycle k+1.
  - It reaches RAM at edge k+1 at the earliest.
- Count update:
  - push&!pop: +1.
  - pop&!push: -1.
  - both: unchanged.
  - Never exceeds DEPTH and never goes below 0.
- Simultaneous push and pop: allowed when count is between 1 and DEPTH-1 inclusive, and when count==0 only if the pop is absent (nothing to pop).
- Order: stores drain strictly in arrival order. There is no merging or coalescing.
- Forwarding (combinational):
  - Compare ld_addr against all valid entries using the full N bits.
  - ld_hit=1 if any match; ld_data = data of the youngest matching entry (closest to wr_ptr).
  - The head entry being drained in the current cycle still counts as valid and is forwarded.
  - A store being pushed in the same cycle is NOT forwarded; the core's hazard logic covers it.
- Overflow: st_valid & full at posedge sets overflow=1. The store is dropped. Only rst clears the flag.
- Flags:
  - empty and full derive from count (combinational on registered count).
  - No glitch-dependent behaviour.

Test Plan:
- Reset → rst=1 for 1 cycle then 0 → count=0, empty=1, full=0, st_ready=1, mem_we=0, overflow=0.
- Single store, drain immediately → store 2 to addr 96 with mem_grant=1 → next cycle mem_we=1, mem_addr=96, mem_wdata=2; following cycle empty=1.
- Ordered drain under stall → mem_grant=0; push (96,2) then (92,4) → count=2, no mem_we. Raise mem_grant → RAM receives 96←2, then 92←4, on consecutive edges.
- Fill/overflow → mem_grant=0; push 5 stores to addrs 0,4,8,12,16 with DEPTH=4 → full=1 and st_ready=0 after the 4th push; 5th store dropped, overflow=1, count=4. Drain yields exactly addrs 0,4,8,12.
- Forwarding youngest → mem_grant=0; push (96,2), (92,7), (96,9); ld_addr=96 → ld_hit=1, ld_data=9. ld_addr=92 → ld_data=7. ld_addr=100 → ld_hit=0, ld_data=0.
- Simultaneous push/pop + reset mid-op → count=2, mem_grant=1, push each cycle → count stays 2 with correct FIFO order. Assert rst with 2 pending → next cycle count=0, mem_we=0, and no further RAM writes.

Source files
------------

// File: rtl/store_write_buffer.sv
// Posted-store FIFO between the core memory stage and data_ram.
// Drains in arrival order on mem_grant and forwards the youngest matching store to loads.
module store_write_buffer #(
    parameter int N     = 10,
    parameter int M     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [N-1:0]             st_addr,
    input  logic [M-1:0]             st_data,
    output logic                     st_ready,
    input  logic [N-1:0]             ld_addr,
    output logic                     ld_hit,
    output logic [M-1:0]             ld_data,
    input  logic                     mem_grant,
    output logic                     mem_we,
    output logic [N-1:0]             mem_addr,
    output logic [M-1:0]             mem_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [N-1:0]  addrMem [DEPTH];
    logic [M-1:0]  dataMem [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] fwdIdx;
    logic          push;
    logic          pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign st_ready = !full;
    assign push     = st_valid && !full;
    // A reset cycle must not leak the pending head into data_ram.
    assign mem_we   = !empty && mem_grant && !rst;
    assign pop      = mem_we;

    assign mem_addr  = empty ? '0 : addrMem[rdPtr];
    assign mem_wdata = empty ? '0 : dataMem[rdPtr];

    always_ff @(posedge clk) begin
        if (push) begin
            addrMem[wrPtr] <= st_addr;
            dataMem[wrPtr] <= st_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + (PW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PW+1)'(1);
            end
            if (st_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fwdIdx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwdIdx = rdPtr + PW'(i);
            if (((PW+1)'(i) < count) && (addrMem[fwdIdx] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = dataMem[fwdIdx];
            end
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer (N=10, M=32, DEPTH=4).
module tb_store_write_buffer;

    localparam int N     = 10;
    localparam int M     = 32;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         st_valid;
    logic [N-1:0] st_addr;
    logic [M-1:0] st_data;
    logic         st_ready;
    logic [N-1:0] ld_addr;
    logic         ld_hit;
    logic [M-1:0] ld_data;
    logic         mem_grant;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [M-1:0] mem_wdata;
    logic [2:0]   count;
    logic         empty;
    logic         full;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    logic [N+M-1:0] ramWrites [$];

    store_write_buffer #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .mem_grant(mem_grant), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .empty(empty), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model of data_ram: record every write it would capture.
    always @(posedge clk) begin
        if (mem_we) ramWrites.push_back({mem_addr, mem_wdata});
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectWrite(input string tag, input logic [N-1:0] a, input logic [M-1:0] d);
        logic [N+M-1:0] w;
        if (ramWrites.size() == 0) begin
            checkVal({tag, "_present"}, 64'd0, 64'd1);
        end else begin
            w = ramWrites.pop_front();
            checkVal({tag, "_addr"}, 64'(w[N+M-1:M]), 64'(a));
            checkVal({tag, "_data"}, 64'(w[M-1:0]), 64'(d));
        end
    endtask

    task automatic pushOne(input logic [N-1:0] a, input logic [M-1:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        tick();
        st_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_addr = '0; mem_grant = 1'b0;

        // Reset state
        tick();
        rst = 1'b0;
        checkVal("rst_count", 64'(count), 64'd0);
        checkVal("rst_empty", 64'(empty), 64'd1);
        checkVal("rst_full", 64'(full), 64'd0);
        checkVal("rst_ready", 64'(st_ready), 64'd1);
        checkVal("rst_we", 64'(mem_we), 64'd0);
        checkVal("rst_ovf", 64'(overflow), 64'd0);
        checkVal("rst_hit", 64'(ld_hit), 64'd0);
        checkVal("rst_ldata", 64'(ld_data), 64'd0);

        // Single store, immediate drain
        mem_grant = 1'b1;
        st_valid = 1'b1; st_addr = 10'd96; st_data = 32'd2;
        checkVal("s1_we_pre", 64'(mem_we), 64'd0);
        tick();
        st_valid = 1'b0;
        checkVal("s1_we", 64'(mem_we), 64'd1);
        checkVal("s1_addr", 64'(mem_addr), 64'd96);
        checkVal("s1_wdata", 64'(mem_wdata), 64'd2);
        tick();
        checkVal("s1_empty", 64'(empty), 64'd1);
        expectWrite("s1_ram", 10'd96, 32'd2);
        checkVal("s1_nwr", 64'(ramWrites.size()), 64'd0);

        // Ordered drain after a stall
        mem_grant = 1'b0;
        pushOne(10'd96, 32'd2);
        pushOne(10'd92, 32'd4);
        checkVal("s2_count", 64'(count), 64'd2);
        checkVal("s2_we", 64'(mem_we), 64'd0);
        mem_grant = 1'b1;
        checkVal("s2_head", 64'(mem_addr), 64'd96);
        tick();
        checkVal("s2_head2", 64'(mem_addr), 64'd92);
        checkVal("s2_count1", 64'(count), 64'd1);
        tick();
        checkVal("s2_count0", 64'(count), 64'd0);
        expectWrite("s2_w0", 10'd96, 32'd2);
        expectWrite("s2_w1", 10'd92, 32'd4);

        // Fill and overflow
        mem_grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkVal($sformatf("s3_ready%0d", i), 64'(st_ready), (i < 4) ? 64'd1 : 64'd0);
            pushOne(10'(4 * i), 32'(100 + i));
        end
        checkVal("s3_full", 64'(full), 64'd1);
        checkVal("s3_ready", 64'(st_ready), 64'd0);
        checkVal("s3_ovf", 64'(overflow), 64'd1);
        checkVal("s3_count", 64'(count), 64'd4);
        mem_grant = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        mem_grant = 1'b0;
        checkVal("s3_empty", 64'(empty), 64'd1);
        for (int i = 0; i < 4; i++) expectWrite($sformatf("s3_w%0d", i), 10'(4 * i), 32'(100 + i));
        checkVal("s3_nwr", 64'(ramWrites.size()), 64'd0);
        checkVal("s3_ovf_sticky", 64'(overflow), 64'd1);

        // Forwarding: youngest match wins, same-cycle push not forwarded
        rst = 1'b1; tick(); rst = 1'b0;
        checkVal("s4_ovf_clr", 64'(overflow), 64'd0);
        ld_addr = 10'd96;
        st_valid = 1'b1; st_addr = 10'd96; st_data = 32'd2;
        checkVal("s4_nobypass", 64'(ld_hit), 64'd0);
        tick();
        st_valid = 1'b0;
        pushOne(10'd92, 32'd7);
        pushOne(10'd96, 32'd9);
        checkVal("s4_hit96", 64'(ld_hit), 64'd1);
        checkVal("s4_data96", 64'(ld_data), 64'd9);
        ld_addr = 10'd92; #1;
        checkVal("s4_hit92", 64'(ld_hit), 64'd1);
        checkVal("s4_data92", 64'(ld_data), 64'd7);
        ld_addr = 10'd100; #1;
        checkVal("s4_hit100", 64'(ld_hit), 64'd0);
        checkVal("s4_data100", 64'(ld_data), 64'd0);
        // Head being drained is still forwarded
        ld_addr = 10'd96; mem_grant = 1'b1; #1;
        checkVal("s4_drainhit", 64'(ld_data), 64'd9);
        tick(); tick();
        checkVal("s4_tailhit", 64'(ld_data), 64'd9);
        tick();
        mem_grant = 1'b0;
        checkVal("s4_empty_hit", 64'(ld_hit), 64'd0);
        expectWrite("s4_w0", 10'd96, 32'd2);
        expectWrite("s4_w1", 10'd92, 32'd7);
        expectWrite("s4_w2", 10'd96, 32'd9);

        // Simultaneous push/pop, then reset with stores pending
        pushOne(10'd10, 32'd1);
        pushOne(10'd20, 32'd2);
        mem_grant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pushOne(10'(30 + 10 * i), 32'(3 + i));
            checkVal($sformatf("s5_count%0d", i), 64'(count), 64'd2);
        end
        expectWrite("s5_w0", 10'd10, 32'd1);
        expectWrite("s5_w1", 10'd20, 32'd2);
        expectWrite("s5_w2", 10'd30, 32'd3);
        checkVal("s5_head", 64'(mem_addr), 64'd40);
        rst = 1'b1; #1;
        checkVal("s5_rst_we", 64'(mem_we), 64'd0);
        tick();
        rst = 1'b0;
        checkVal("s5_count_rst", 64'(count), 64'd0);
        checkVal("s5_we_rst", 64'(mem_we), 64'd0);
        tick(); tick();
        checkVal("s5_nwr", 64'(ramWrites.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
